// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: unsigned 8x8 -> 16-bit multiply sequenced over one shared external 4x4 multiplier.
// Four nibble partial products are issued in a fixed order and shift-accumulated into the result.
module mul8_seq_ctrl #(
   parameter int MUL_LAT = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  op_a,
   input  logic [7:0]  op_b,
   output logic [3:0]  mul_a,
   output logic [3:0]  mul_b,
   input  logic [7:0]  mul_p,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_STEP = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Last wait-counter value before the multiplier output is valid.
   localparam logic [1:0] WAIT_LAST = (MUL_LAT > 1) ? 2'(MUL_LAT - 1) : 2'd0;

   state_t      r_state;
   logic [1:0]  r_step;
   logic [1:0]  r_wait_cnt;
   logic [15:0] r_acc;
   logic [7:0]  r_a;
   logic [7:0]  r_b;
   logic [3:0]  r_mul_a;
   logic [3:0]  r_mul_b;
   logic        r_out_valid;
   logic        r_busy;
   logic [15:0] r_result;

   logic [15:0] w_pp_shifted;
   logic [15:0] w_acc_sum;
   logic [1:0]  w_step_nxt;
   logic        w_last;
   logic        w_pp_done;

   // Step order: lo*lo, hi*lo, lo*hi, hi*hi.
   function automatic logic [3:0] nib_a(input logic [7:0] a, input logic [1:0] step);
      return step[0] ? a[7:4] : a[3:0];
   endfunction

   function automatic logic [3:0] nib_b(input logic [7:0] b, input logic [1:0] step);
      return step[1] ? b[7:4] : b[3:0];
   endfunction

   function automatic logic [15:0] align_pp(input logic [7:0] p, input logic [1:0] step);
      logic [15:0] v;
      v = {8'h00, p};
      case (step)
         2'd0:    align_pp = v;
         2'd3:    align_pp = v << 8;
         default: align_pp = v << 4;
      endcase
   endfunction

   assign w_pp_shifted = align_pp(mul_p, r_step);
   assign w_acc_sum    = r_acc + w_pp_shifted;
   assign w_step_nxt   = r_step + 2'd1;
   assign w_last       = (r_step == 2'd3);
   assign w_pp_done    = (MUL_LAT == 0) ? (r_state == S_STEP)
                                        : ((r_state == S_WAIT) && (r_wait_cnt == WAIT_LAST));

   assign in_ready  = (r_state == S_IDLE) && ena;
   assign mul_a     = r_mul_a;
   assign mul_b     = r_mul_b;
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign busy      = r_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_step      <= 2'd0;
         r_wait_cnt  <= 2'd0;
         r_acc       <= 16'h0000;
         r_a         <= 8'h00;
         r_b         <= 8'h00;
         r_mul_a     <= 4'h0;
         r_mul_b     <= 4'h0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_result    <= 16'h0000;
      end else if (ena) begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a        <= op_a;
                  r_b        <= op_b;
                  r_acc      <= 16'h0000;
                  r_step     <= 2'd0;
                  r_wait_cnt <= 2'd0;
                  r_mul_a    <= nib_a(op_a, 2'd0);
                  r_mul_b    <= nib_b(op_b, 2'd0);
                  r_busy     <= 1'b1;
                  r_state    <= S_STEP;
               end
            end
            S_STEP, S_WAIT: begin
               if (w_pp_done) begin
                  r_acc <= w_acc_sum;
                  if (w_last) begin
                     r_result    <= w_acc_sum;
                     r_out_valid <= 1'b1;
                     r_mul_a     <= 4'h0;
                     r_mul_b     <= 4'h0;
                     r_state     <= S_DONE;
                  end else begin
                     r_step  <= w_step_nxt;
                     r_mul_a <= nib_a(r_a, w_step_nxt);
                     r_mul_b <= nib_b(r_b, w_step_nxt);
                     r_state <= S_STEP;
                  end
               end else if (r_state == S_STEP) begin
                  // Registered multiplier: operands stay put while its output settles.
                  r_wait_cnt <= 2'd0;
                  r_state    <= S_WAIT;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 2'd1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Bench for mul8_seq_ctrl: one instance with a combinational 4x4 multiplier, one with a registered one.
module tb_mul8_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena[2];
   logic        in_valid[2];
   logic        in_ready[2];
   logic [7:0]  op_a[2];
   logic [7:0]  op_b[2];
   logic [3:0]  mul_a[2];
   logic [3:0]  mul_b[2];
   logic [7:0]  mul_p0;
   logic [7:0]  mul_p1 = 8'h00;
   logic        out_valid[2];
   logic        out_ready[2];
   logic [15:0] result[2];
   logic        busy[2];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int acc_cyc = 0;

   typedef struct {
      int          d;
      logic [7:0]  a;
      logic [7:0]  b;
      int          hold;
      logic [15:0] exp;
   } vec_t;
   vec_t tbl[6];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // External nibble multipliers: zero latency and one register stage.
   assign mul_p0 = {4'h0, mul_a[0]} * {4'h0, mul_b[0]};
   always_ff @(posedge clk) mul_p1 <= {4'h0, mul_a[1]} * {4'h0, mul_b[1]};

   mul8_seq_ctrl #(.MUL_LAT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .ena(ena[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .op_a(op_a[0]), .op_b(op_b[0]), .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_p(mul_p0),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]), .busy(busy[0])
   );

   mul8_seq_ctrl #(.MUL_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .op_a(op_a[1]), .op_b(op_b[1]), .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_p(mul_p1),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]), .busy(busy[1])
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One full transaction; the model is the plain product, the fixed latency
   // and the nibble each step must present.
   task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                         input int hold, input logic [15:0] exp);
      int n;
      int lat;
      int s;
      logic [7:0] nib;
      lat = (d == 1) ? 8 : 4;
      n = 0;
      while (!in_ready[d] && n < 20) begin
         tick();
         n++;
      end
      tests++;
      if (!in_ready[d]) begin
         fails++;
         $display("FAIL in_ready_timeout: dut%0d in_ready stayed %0d", d, in_ready[d]);
         return;
      end
      op_a[d] = a;
      op_b[d] = b;
      in_valid[d] = 1'b1;
      tick();
      acc_cyc = cyc;
      in_valid[d] = 1'b0;
      op_a[d] = 8'($urandom);
      op_b[d] = 8'($urandom);
      for (int i = 0; i < lat; i++) begin
         s = (d == 1) ? i / 2 : i;
         nib[7:4] = (s % 2 == 1) ? a[7:4] : a[3:0];
         nib[3:0] = (s >= 2) ? b[7:4] : b[3:0];
         chk($sformatf("nibbles_dut%0d_c%0d", d, i), {mul_a[d], mul_b[d]}, nib);
         chk($sformatf("busy_noval_dut%0d_c%0d", d, i), {in_ready[d], busy[d], out_valid[d]}, 3'b010);
         tick();
      end
      chk($sformatf("done_dut%0d", d), {in_ready[d], out_valid[d], mul_a[d], mul_b[d], result[d]},
          {1'b0, 1'b1, 8'h00, exp});
      out_ready[d] = 1'b0;
      for (int h = 0; h < hold; h++) begin
         tick();
         chk($sformatf("done_hold_dut%0d", d), {in_ready[d], out_valid[d], result[d]}, {1'b0, 1'b1, exp});
      end
      out_ready[d] = 1'b1;
      tick();
      out_ready[d] = 1'b0;
      chk($sformatf("after_hs_dut%0d", d), {in_ready[d], out_valid[d], busy[d], result[d]},
          {1'b1, 1'b0, 1'b0, exp});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int prev_acc;
      logic [7:0] ra;
      logic [7:0] rb;
      int rd;

      tbl[0] = '{0, 8'hFF, 8'hFF, 0, 16'hFE01};
      tbl[1] = '{0, 8'h3C, 8'hA5, 6, 16'h26AC};
      tbl[2] = '{0, 8'h00, 8'h7B, 0, 16'h0000};
      tbl[3] = '{0, 8'h12, 8'h34, 0, 16'h03A8};
      tbl[4] = '{1, 8'hC8, 8'h19, 0, 16'h1388};
      tbl[5] = '{1, 8'hFF, 8'hFF, 2, 16'hFE01};

      for (int d = 0; d < 2; d++) begin
         ena[d] = 1'b1;
         in_valid[d] = 1'b0;
         op_a[d] = 8'h00;
         op_b[d] = 8'h00;
         out_ready[d] = 1'b0;
      end

      // Reset state
      #3;
      chk("rst_outputs", {in_ready[0], out_valid[0], busy[0], mul_a[0], mul_b[0], result[0]},
          {1'b1, 1'b0, 1'b0, 8'h00, 16'h0000});
      ena[0] = 1'b0;
      #1;
      chk("rst_in_ready_ena0", {31'h0, in_ready[0]}, 32'h0);
      ena[0] = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Table-driven vectors
      prev_acc = 0;
      for (int i = 0; i < 6; i++) begin
         run_op(tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].exp);
         if (i == 3) chk("b2b_accept_spacing", acc_cyc - prev_acc, 6);
         prev_acc = acc_cyc;
      end

      // Stall during step2 of 0x81*0x81
      op_a[0] = 8'h81;
      op_b[0] = 8'h81;
      in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      tick();
      tick();
      chk("stall_step2_nib", {mul_a[0], mul_b[0]}, 8'h18);
      ena[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_hold", {in_ready[0], busy[0], out_valid[0], mul_a[0], mul_b[0]}, {3'b010, 8'h18});
      end
      ena[0] = 1'b1;
      tick();
      chk("stall_step3_nib", {out_valid[0], mul_a[0], mul_b[0]}, {1'b0, 8'h88});
      tick();
      chk("stall_done", {out_valid[0], result[0]}, {1'b1, 16'h4101});
      ena[0] = 1'b0;
      out_ready[0] = 1'b1;
      tick();
      chk("out_ready_ignored_ena0", {out_valid[0], busy[0], result[0]}, {2'b11, 16'h4101});
      ena[0] = 1'b1;
      tick();
      out_ready[0] = 1'b0;
      chk("stall_after_hs", {in_ready[0], out_valid[0], busy[0]}, 3'b100);

      // Reset during step1 of 0xFF*0x02
      op_a[0] = 8'hFF;
      op_b[0] = 8'h02;
      in_valid[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0;
      tick();
      chk("pre_rst_step1_nib", {mul_a[0], mul_b[0]}, 8'hF2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_abort", {in_ready[0], out_valid[0], busy[0], mul_a[0], mul_b[0], result[0]},
          {3'b100, 8'h00, 16'h0000});
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("no_result_after_abort", {out_valid[0], busy[0]}, 2'b00);
      end
      run_op(0, 8'h05, 8'h06, 0, 16'h001E);

      // Randomized transactions against the arithmetic model
      for (int i = 0; i < 30; i++) begin
         rd = i % 2;
         ra = 8'($urandom);
         rb = 8'($urandom);
         if (i % 7 == 3) ra = 8'hFF;
         if (i % 5 == 2) rb = 8'h00;
         run_op(rd, ra, rb, int'($urandom_range(0, 3)), 16'(ra) * 16'(rb));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
